// File: rtl/alu_share_arbiter.sv
// alu_share_arbiter
//   Shares a single combinational 8-bit ALU among NREQ requesters.
//   Requests are picked round-robin, the winner's operands are registered onto
//   the ALU port, and the result is captured and returned over valid/ready.
//   Divide/modulo by zero and undefined op codes return rsp_err=1 with zero data.
//
// Ports
//   clk, rst              rising-edge clock, synchronous active-high reset
//   req_valid/req_ready   per-requester handshake (req_ready one-hot or zero)
//   req_a/req_b           packed 8-bit operands, requester i at [8i+7:8i]
//   req_op                packed 4-bit op codes, requester i at [4i+3:4i]
//   rsp_valid/rsp_ready   response handshake
//   rsp_id                index of the requester owning the response
//   rsp_data, rsp_err     result and invalid-operation flag
//   alu_a/alu_b/alu_op    registered operands driven to the shared ALU
//   alu_result            combinational ALU result
//   busy                  high whenever an operation is in flight
module alu_share_arbiter #(
   parameter  int NREQ = 4,
   localparam int IDW  = $clog2(NREQ)
) (
   input  logic                clk,
   input  logic                rst,
   input  logic [NREQ-1:0]     req_valid,
   output logic [NREQ-1:0]     req_ready,
   input  logic [8*NREQ-1:0]   req_a,
   input  logic [8*NREQ-1:0]   req_b,
   input  logic [4*NREQ-1:0]   req_op,
   output logic                rsp_valid,
   input  logic                rsp_ready,
   output logic [IDW-1:0]      rsp_id,
   output logic [15:0]         rsp_data,
   output logic                rsp_err,
   output logic [7:0]          alu_a,
   output logic [7:0]          alu_b,
   output logic [3:0]          alu_op,
   input  logic [15:0]         alu_result,
   output logic                busy
);

   typedef enum logic [1:0] {IDLE, ISSUE, RESPOND} state_t;

   state_t         state, state_nxt;
   logic [IDW-1:0] ptr;
   logic [IDW-1:0] grant;
   logic           any_valid;
   logic [7:0]     sel_a, sel_b;
   logic [3:0]     sel_op;

   // Division/modulo by zero and the unused op range 8..15 are reported as errors.
   function automatic logic op_invalid(input logic [3:0] op, input logic [7:0] b);
      return (((op == 4'd2) || (op == 4'd3)) && (b == 8'd0)) || op[3];
   endfunction

   // Modulo-NREQ increment; NREQ need not be a power of two.
   function automatic logic [IDW-1:0] wrap_inc(input logic [IDW-1:0] v);
      return (v == IDW'(NREQ-1)) ? '0 : v + IDW'(1);
   endfunction

   assign any_valid = |req_valid;

   // Round-robin search starting at ptr: the first valid requester wins.
   always_comb begin
      logic [IDW-1:0] idx;
      logic           found;
      grant = ptr;
      found = 1'b0;
      idx   = ptr;
      for (int k = 0; k < NREQ; k++) begin
         if (!found && req_valid[idx]) begin
            grant = idx;
            found = 1'b1;
         end
         idx = wrap_inc(idx);
      end
   end

   // Operand mux for the winning requester.
   always_comb begin
      sel_a  = '0;
      sel_b  = '0;
      sel_op = '0;
      for (int i = 0; i < NREQ; i++) begin
         if (grant == IDW'(i)) begin
            sel_a  = req_a[8*i +: 8];
            sel_b  = req_b[8*i +: 8];
            sel_op = req_op[4*i +: 4];
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) state <= IDLE;
      else     state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      req_ready = '0;
      busy      = 1'b1;
      case (state)
         IDLE: begin
            busy = 1'b0;
            if (any_valid) begin
               for (int i = 0; i < NREQ; i++) req_ready[i] = (grant == IDW'(i));
               state_nxt = ISSUE;
            end
         end
         ISSUE:   state_nxt = RESPOND;
         RESPOND: if (rsp_ready) state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   // ALU operands stay at their last issued value outside of ISSUE; the
   // response fields only change on capture or handshake, so they are stable
   // under backpressure.
   always_ff @(posedge clk) begin
      if (rst) begin
         ptr       <= '0;
         alu_a     <= '0;
         alu_b     <= '0;
         alu_op    <= '0;
         rsp_valid <= 1'b0;
         rsp_id    <= '0;
         rsp_data  <= '0;
         rsp_err   <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (any_valid) begin
                  alu_a  <= sel_a;
                  alu_b  <= sel_b;
                  alu_op <= sel_op;
                  rsp_id <= grant;
               end
            end
            ISSUE: begin
               rsp_valid <= 1'b1;
               if (op_invalid(alu_op, alu_b)) begin
                  rsp_data <= '0;
                  rsp_err  <= 1'b1;
               end else begin
                  rsp_data <= alu_result;
                  rsp_err  <= 1'b0;
               end
            end
            RESPOND: begin
               if (rsp_ready) begin
                  rsp_valid <= 1'b0;
                  ptr       <= wrap_inc(rsp_id);
               end
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_alu_share_arbiter.sv
// tb_alu_share_arbiter
//   Bench for alu_share_arbiter with NREQ=4. Provides a behavioural ALU,
//   directed scenarios and a randomized phase. A transaction-level model
//   (round-robin pick, expected result, latency, ptr) is evaluated every
//   cycle at the falling edge; inputs change just after the rising edge.
module tb_alu_share_arbiter;
   localparam int NREQ = 4;
   localparam int IDW  = 2;
   localparam int AW   = 8 * NREQ;
   localparam int OW   = 4 * NREQ;

   logic              clk = 1'b0;
   logic              rst;
   logic [NREQ-1:0]   req_valid, req_ready;
   logic [AW-1:0]     req_a, req_b;
   logic [OW-1:0]     req_op;
   logic              rsp_valid, rsp_ready;
   logic [IDW-1:0]    rsp_id;
   logic [15:0]       rsp_data;
   logic              rsp_err;
   logic [7:0]        alu_a, alu_b;
   logic [3:0]        alu_op;
   logic [15:0]       alu_result;
   logic              busy;

   int errors = 0;
   int checks = 0;

   always #5 clk = ~clk;

   alu_share_arbiter #(.NREQ(NREQ)) dut (
      .clk(clk), .rst(rst),
      .req_valid(req_valid), .req_ready(req_ready),
      .req_a(req_a), .req_b(req_b), .req_op(req_op),
      .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
      .rsp_id(rsp_id), .rsp_data(rsp_data), .rsp_err(rsp_err),
      .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op),
      .alu_result(alu_result), .busy(busy)
   );

   // Behavioural ALU; division by zero yields a recognisable junk value.
   function automatic logic [15:0] alu_f(input logic [7:0] a, input logic [7:0] b,
                                         input logic [3:0] op);
      case (op)
         4'd0: return 16'(a) + 16'(b);
         4'd1: return 16'(a) - 16'(b);
         4'd2: return (b == 8'd0) ? 16'hDEAD : 16'(a / b);
         4'd3: return (b == 8'd0) ? 16'hBEEF : 16'(a % b);
         4'd4: return 16'(a) * 16'(a);
         4'd5: return {8'h00, a & b};
         4'd6: return {8'h00, a | b};
         4'd7: return {8'h00, ~a};
         default: return 16'h0000;
      endcase
   endfunction

   assign alu_result = alu_f(alu_a, alu_b, alu_op);

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
      end
   endtask

   // ---------------- reference model ----------------
   typedef struct {
      int          id;
      logic [15:0] data;
      logic        err;
      int          acc;
   } txn_t;

   txn_t q[$];
   int   ptr_m = 0;
   int   cyc   = 0;

   // snapshots of DUT outputs taken at the falling edge
   logic [NREQ-1:0] s_ready;
   logic            s_rv, s_err, s_busy;
   logic [IDW-1:0]  s_id;
   logic [15:0]     s_data;
   logic [7:0]      s_alu_a, s_alu_b;
   logic [3:0]      s_alu_op;

   function automatic int rr_pick(input logic [NREQ-1:0] v, input int p);
      for (int k = 0; k < NREQ; k++) begin
         if (v[IDW'((p + k) % NREQ)]) return (p + k) % NREQ;
      end
      return -1;
   endfunction

   task automatic tick();
      int              g;
      logic [NREQ-1:0] exp_r;
      logic [7:0]      a, b;
      logic [3:0]      op;
      logic            due;
      txn_t            t;
      @(negedge clk);
      cyc++;
      s_ready = req_ready; s_rv = rsp_valid; s_err = rsp_err; s_busy = busy;
      s_id = rsp_id; s_data = rsp_data;
      s_alu_a = alu_a; s_alu_b = alu_b; s_alu_op = alu_op;
      if (rst) begin
         q.delete();
         ptr_m = 0;
      end else begin
         check("busy", 32'(busy), 32'(q.size() != 0));
         if (q.size() == 0) begin
            g = rr_pick(req_valid, ptr_m);
            exp_r = (g < 0) ? '0 : (NREQ'(1) << g);
            check("req_ready", 32'(req_ready), 32'(exp_r));
            check("rsp_valid_idle", 32'(rsp_valid), 32'(0));
            if (g >= 0) begin
               a  = 8'(req_a >> (8 * g));
               b  = 8'(req_b >> (8 * g));
               op = 4'(req_op >> (4 * g));
               t.id  = g;
               t.err = (((op == 4'd2) || (op == 4'd3)) && (b == 8'd0)) || (op >= 4'd8);
               t.data = t.err ? 16'h0000 : alu_f(a, b, op);
               t.acc = cyc;
               q.push_back(t);
            end
         end else begin
            check("req_ready_busy", 32'(req_ready), 32'(0));
            due = (cyc >= q[0].acc + 2);
            check("rsp_valid", 32'(rsp_valid), 32'(due));
            if (due && rsp_valid) begin
               check("rsp_id", 32'(rsp_id), 32'(q[0].id));
               check("rsp_data", 32'(rsp_data), 32'(q[0].data));
               check("rsp_err", 32'(rsp_err), 32'(q[0].err));
               if (rsp_ready) begin
                  ptr_m = (q[0].id + 1) % NREQ;
                  void'(q.pop_front());
               end
            end
         end
      end
      @(posedge clk);
      #1;
   endtask

   // ---------------- stimulus helpers ----------------
   task automatic set_req(input int i, input logic [7:0] a, input logic [7:0] b,
                          input logic [3:0] op);
      req_a     = (req_a  & ~(AW'(8'hFF) << (8 * i))) | (AW'(a) << (8 * i));
      req_b     = (req_b  & ~(AW'(8'hFF) << (8 * i))) | (AW'(b) << (8 * i));
      req_op    = (req_op & ~(OW'(4'hF)  << (4 * i))) | (OW'(op) << (4 * i));
      req_valid = req_valid | (NREQ'(1) << i);
   endtask

   task automatic drop_req(input int i);
      req_valid = req_valid & ~(NREQ'(1) << i);
   endtask

   task automatic wait_ready(input int i);
      for (int k = 0; k < 20; k++) begin
         tick();
         if ((s_ready & (NREQ'(1) << i)) != '0) return;
      end
      check("accept_timeout", 32'(0), 32'(1));
   endtask

   task automatic wait_any(output int g);
      g = -1;
      for (int k = 0; k < 20; k++) begin
         tick();
         if (s_ready != '0) begin
            for (int j = 0; j < NREQ; j++)
               if (s_ready[IDW'(j)]) g = j;
            return;
         end
      end
      check("grant_timeout", 32'(0), 32'(1));
   endtask

   task automatic do_op(input int i, input logic [7:0] a, input logic [7:0] b,
                        input logic [3:0] op, output logic [15:0] d,
                        output logic e, output int id, output int lat);
      set_req(i, a, b, op);
      wait_ready(i);
      drop_req(i);
      lat = 0;
      for (int k = 0; k < 20; k++) begin
         tick();
         lat++;
         if (s_rv) break;
      end
      d  = s_data;
      e  = s_err;
      id = int'(s_id);
   endtask

   logic [15:0] d, d0;
   logic        e, e0;
   int          id, id0, lat, g, prev;
   logic [7:0]  ra, rb;
   logic [3:0]  rop;

   initial begin
      rst = 1'b1; req_valid = '0; req_a = '0; req_b = '0; req_op = '0; rsp_ready = 1'b0;
      @(posedge clk); #1;
      tick(); tick();
      rst = 1'b0;
      tick();
      check("rst_rsp_valid", 32'(s_rv), 32'(0));
      check("rst_rsp_id", 32'(s_id), 32'(0));
      check("rst_rsp_data", 32'(s_data), 32'(0));
      check("rst_rsp_err", 32'(s_err), 32'(0));
      check("rst_alu", {12'h0, s_alu_a, s_alu_b, s_alu_op}, 32'(0));
      check("rst_busy", 32'(s_busy), 32'(0));
      check("rst_req_ready", 32'(s_ready), 32'(0));

      // single requester
      rsp_ready = 1'b1;
      do_op(1, 8'h12, 8'h34, 4'd0, d, e, id, lat);
      check("single_lat", 32'(lat), 32'(2));
      check("single_id", 32'(id), 32'(1));
      check("single_data", 32'(d), 32'h0046);
      check("single_err", 32'(e), 32'(0));
      tick();

      // all four continuously valid: strict rotation, one op per 3 cycles
      rst = 1'b1; tick(); rst = 1'b0;
      for (int i = 0; i < NREQ; i++) set_req(i, 8'hFF, 8'h01, 4'd0);
      prev = 0;
      for (int n = 0; n < 5; n++) begin
         wait_any(g);
         check("rr_order", 32'(g), 32'(n % NREQ));
         if (n > 0) check("rr_spacing", 32'(cyc - prev), 32'(3));
         prev = cyc;
         tick(); tick();
         check("rr_rsp_valid", 32'(s_rv), 32'(1));
         check("rr_data", 32'(s_data), 32'h0100);
      end
      req_valid = '0;
      tick(); tick();

      // backpressure: response held, nobody else accepted
      rsp_ready = 1'b0;
      set_req(3, 8'h05, 8'h07, 4'd4);
      wait_ready(3);
      drop_req(3);
      set_req(0, 8'h01, 8'h01, 4'd0);
      tick(); tick();
      d0 = s_data; id0 = int'(s_id); e0 = s_err;
      check("bp_first", {s_rv, s_id, s_data}, {1'b1, 2'd3, 16'h0019});
      for (int k = 0; k < 5; k++) begin
         tick();
         check("bp_hold", {s_rv, s_id, s_err, s_data}, {1'b1, IDW'(id0), e0, d0});
         check("bp_ready", 32'(s_ready), 32'(0));
      end
      rsp_ready = 1'b1;
      tick();
      wait_ready(0);
      drop_req(0);
      tick(); tick(); tick();

      // error handling and wrap-around arithmetic
      do_op(0, 8'h09, 8'h00, 4'd2, d, e, id, lat);
      check("div0", {e, d}, {1'b1, 16'h0000});
      do_op(1, 8'h09, 8'h04, 4'd3, d, e, id, lat);
      check("mod", {e, d}, {1'b0, 16'h0001});
      do_op(2, 8'h21, 8'h03, 4'd9, d, e, id, lat);
      check("op9", {e, d}, {1'b1, 16'h0000});
      do_op(0, 8'h03, 8'h05, 4'd1, d, e, id, lat);
      check("sub_wrap", {e, d}, {1'b0, 16'hFFFE});

      // fairness after wrap: ptr at 3, requesters 0 and 3 pending
      do_op(2, 8'h02, 8'h03, 4'd5, d, e, id, lat);
      set_req(0, 8'h0A, 8'h01, 4'd6);
      set_req(3, 8'h0B, 8'h01, 4'd7);
      wait_any(g);
      check("wrap_first", 32'(g), 32'(3));
      drop_req(3);
      wait_any(g);
      check("wrap_second", 32'(g), 32'(0));
      drop_req(0);
      tick(); tick(); tick();

      // reset while in ISSUE
      do_op(1, 8'h01, 8'h02, 4'd0, d, e, id, lat);
      set_req(2, 8'h10, 8'h03, 4'd2);
      wait_ready(2);
      drop_req(2);
      rst = 1'b1;
      tick();
      rst = 1'b0;
      tick();
      check("rst_mid_valid", 32'(s_rv), 32'(0));
      check("rst_mid_busy", 32'(s_busy), 32'(0));
      set_req(0, 8'h04, 8'h04, 4'd0);
      set_req(2, 8'h10, 8'h03, 4'd2);
      wait_any(g);
      check("rst_ptr_grant", 32'(g), 32'(0));
      drop_req(0);
      wait_any(g);
      check("rst_next_grant", 32'(g), 32'(2));
      drop_req(2);
      tick(); tick();
      check("rst_req2_rsp", {s_rv, s_id, s_err, s_data}, {1'b1, 2'd2, 1'b0, 16'h0005});
      tick();

      // randomized traffic; the model checks every cycle
      for (int n = 0; n < 3000; n++) begin
         for (int i = 0; i < NREQ; i++) begin
            if (s_ready[IDW'(i)]) drop_req(i);
            if (!req_valid[IDW'(i)]) begin
               if ($urandom_range(2) == 0) begin
                  ra  = 8'($urandom);
                  rb  = ($urandom_range(5) == 0) ? 8'h00 : 8'($urandom);
                  rop = ($urandom_range(3) == 0) ? 4'($urandom) : 4'($urandom_range(7));
                  set_req(i, ra, rb, rop);
               end
            end else if ($urandom_range(19) == 0) begin
               drop_req(i);
            end
         end
         rsp_ready = ($urandom_range(2) != 0);
         rst = ($urandom_range(399) == 0);
         tick();
      end
      rst = 1'b0;
      req_valid = '0;
      rsp_ready = 1'b1;
      repeat (5) tick();

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
